mem_port_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares a single physical memory port between the core's instruction bus (ibus) and data bus (dbus). Sits between the core and the memory model or memory controller in the SoC top level. It latches the granted request, drives the shared port until the slave answers or a watchdog expires, then returns read data and a one-cycle ready pulse to the requesting master.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master (ibus/dbus) arbiter onto one shared memory port with a response watchdog.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise dbus has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MASK_W  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_ibus_req,
  input  logic              I_ibus_we,
  input  logic [ADDR_W-1:0] I_ibus_addr,
  input  logic [DATA_W-1:0] I_ibus_data,
  input  logic [MASK_W-1:0] I_ibus_mask,
  output logic [DATA_W-1:0] O_ibus_data,
  output logic              O_ibus_ready,
  output logic              O_ibus_err,
  input  logic              I_dbus_req,
  input  logic              I_dbus_we,
  input  logic [ADDR_W-1:0] I_dbus_addr,
  input  logic [DATA_W-1:0] I_dbus_data,
  input  logic [MASK_W-1:0] I_dbus_mask,
  output logic [DATA_W-1:0] O_dbus_data,
  output logic              O_dbus_ready,
  output logic              O_dbus_err,
  output logic              O_mem_req,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [DATA_W-1:0] O_mem_data,
  output logic [MASK_W-1:0] O_mem_mask,
  input  logic [DATA_W-1:0] I_mem_data,
  input  logic              I_mem_ready,
  output logic              O_busy
);

  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               WD_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_nx;
  logic               grant, grant_nx;
  logic [CNT_W-1:0]   wd_cnt, wd_cnt_nx;
  logic               pick;
  logic               mem_we_nx;
  logic [ADDR_W-1:0]  mem_addr_nx;
  logic [DATA_W-1:0]  mem_data_nx;
  logic [MASK_W-1:0]  mem_mask_nx;
  logic [DATA_W-1:0]  ibus_data_nx, dbus_data_nx;
  logic               ibus_err_nx, dbus_err_nx;
  logic               ibus_ready_nx, dbus_ready_nx;
  logic               mem_req_nx, busy_nx;

  // Tie-break: pick = 1 selects dbus
`ifdef ARB_RR_EN
  logic last, last_nx;
  always_comb begin
    if (I_ibus_req && I_dbus_req) pick = ~last;
    else                          pick = I_dbus_req;
  end
`else
  always_comb pick = I_dbus_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 1'b0;
      wd_cnt       <= '0;
      O_mem_req    <= 1'b0;
      O_mem_we     <= 1'b0;
      O_mem_addr   <= '0;
      O_mem_data   <= '0;
      O_mem_mask   <= '0;
      O_ibus_data  <= '0;
      O_dbus_data  <= '0;
      O_ibus_err   <= 1'b0;
      O_dbus_err   <= 1'b0;
      O_ibus_ready <= 1'b0;
      O_dbus_ready <= 1'b0;
      O_busy       <= 1'b0;
`ifdef ARB_RR_EN
      last         <= 1'b1;
`endif
    end else begin
      state        <= state_nx;
      grant        <= grant_nx;
      wd_cnt       <= wd_cnt_nx;
      O_mem_req    <= mem_req_nx;
      O_mem_we     <= mem_we_nx;
      O_mem_addr   <= mem_addr_nx;
      O_mem_data   <= mem_data_nx;
      O_mem_mask   <= mem_mask_nx;
      O_ibus_data  <= ibus_data_nx;
      O_dbus_data  <= dbus_data_nx;
      O_ibus_err   <= ibus_err_nx;
      O_dbus_err   <= dbus_err_nx;
      O_ibus_ready <= ibus_ready_nx;
      O_dbus_ready <= dbus_ready_nx;
      O_busy       <= busy_nx;
`ifdef ARB_RR_EN
      last         <= last_nx;
`endif
    end
  end

  // Next state; all registered outputs are computed from the state being entered
  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    wd_cnt_nx    = wd_cnt;
    mem_we_nx    = O_mem_we;
    mem_addr_nx  = O_mem_addr;
    mem_data_nx  = O_mem_data;
    mem_mask_nx  = O_mem_mask;
    ibus_data_nx = O_ibus_data;
    dbus_data_nx = O_dbus_data;
    ibus_err_nx  = O_ibus_err;
    dbus_err_nx  = O_dbus_err;
`ifdef ARB_RR_EN
    last_nx      = last;
`endif
    case (state)
      IDLE: begin
        if (I_ibus_req || I_dbus_req) begin
          grant_nx    = pick;
`ifdef ARB_RR_EN
          last_nx     = pick;
`endif
          mem_we_nx   = pick ? I_dbus_we   : I_ibus_we;
          mem_addr_nx = pick ? I_dbus_addr : I_ibus_addr;
          mem_data_nx = pick ? I_dbus_data : I_ibus_data;
          mem_mask_nx = pick ? I_dbus_mask : I_ibus_mask;
          wd_cnt_nx   = '0;
          state_nx    = ACCESS;
        end
      end
      ACCESS: begin
        if (O_mem_req && I_mem_ready) begin
          if (grant) begin
            dbus_data_nx = I_mem_data;
            dbus_err_nx  = 1'b0;
          end else begin
            ibus_data_nx = I_mem_data;
            ibus_err_nx  = 1'b0;
          end
          state_nx = RESP;
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          if (grant) begin
            dbus_data_nx = '0;
            dbus_err_nx  = 1'b1;
          end else begin
            ibus_data_nx = '0;
            ibus_err_nx  = 1'b1;
          end
          state_nx = RESP;
        end else if (wd_cnt != CNT_MAX) begin
          wd_cnt_nx = wd_cnt + CNT_W'(1);
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    mem_req_nx    = (state_nx == ACCESS);
    busy_nx       = (state_nx != IDLE);
    ibus_ready_nx = (state_nx == RESP) && !grant_nx;
    dbus_ready_nx = (state_nx == RESP) &&  grant_nx;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transfers, arbitration ties, reset abort, watchdog.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut1: default watchdog, bench slave
  logic        ib_req, ib_we, db_req, db_we;
  logic [31:0] ib_addr, ib_wdata, db_addr, db_wdata;
  logic [3:0]  ib_mask, db_mask;
  logic [31:0] ib_rdata, db_rdata;
  logic        ib_ready, db_ready, ib_err, db_err;
  logic        mem_req, mem_we, mem_ready, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;

  // dut2: TIMEOUT = 4, slave never answers
  logic        i2_req;
  logic [31:0] i2_addr;
  logic [31:0] u2_ib_rdata, u2_db_rdata, u2_mem_addr, u2_mem_wdata;
  logic        u2_ib_ready, u2_db_ready, u2_ib_err, u2_db_err;
  logic        u2_mem_req, u2_mem_we, u2_busy;
  logic [3:0]  u2_mem_mask;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .I_ibus_req(ib_req), .I_ibus_we(ib_we), .I_ibus_addr(ib_addr), .I_ibus_data(ib_wdata),
    .I_ibus_mask(ib_mask), .O_ibus_data(ib_rdata), .O_ibus_ready(ib_ready), .O_ibus_err(ib_err),
    .I_dbus_req(db_req), .I_dbus_we(db_we), .I_dbus_addr(db_addr), .I_dbus_data(db_wdata),
    .I_dbus_mask(db_mask), .O_dbus_data(db_rdata), .O_dbus_ready(db_ready), .O_dbus_err(db_err),
    .O_mem_req(mem_req), .O_mem_we(mem_we), .O_mem_addr(mem_addr), .O_mem_data(mem_wdata),
    .O_mem_mask(mem_mask), .I_mem_data(mem_rdata), .I_mem_ready(mem_ready), .O_busy(busy)
  );

  mem_port_arbiter #(.TIMEOUT(4)) dut2 (
    .clk(clk), .rst(rst),
    .I_ibus_req(i2_req), .I_ibus_we(1'b0), .I_ibus_addr(i2_addr), .I_ibus_data(32'h0),
    .I_ibus_mask(4'hF), .O_ibus_data(u2_ib_rdata), .O_ibus_ready(u2_ib_ready), .O_ibus_err(u2_ib_err),
    .I_dbus_req(1'b0), .I_dbus_we(1'b0), .I_dbus_addr(32'h0), .I_dbus_data(32'h0),
    .I_dbus_mask(4'h0), .O_dbus_data(u2_db_rdata), .O_dbus_ready(u2_db_ready), .O_dbus_err(u2_db_err),
    .O_mem_req(u2_mem_req), .O_mem_we(u2_mem_we), .O_mem_addr(u2_mem_addr), .O_mem_data(u2_mem_wdata),
    .O_mem_mask(u2_mem_mask), .I_mem_data(32'hFFFF_FFFF), .I_mem_ready(1'b0), .O_busy(u2_busy)
  );

  // Slave: answers slave_delay cycles after the request appears, data = key ^ addr
  int          slave_delay = 0;
  logic [31:0] slave_key = 32'h0;
  int          acc_cnt = 0;
  always @(posedge clk) acc_cnt <= mem_req ? acc_cnt + 1 : 0;
  assign mem_ready = mem_req && (acc_cnt == slave_delay);
  assign mem_rdata = slave_key ^ mem_addr;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        m;
    logic [31:0] data;
    logic        err;
    int          at;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  // Monitors: every ready pulse must match the head of its queue, including cycle
  always @(negedge clk) begin
    if (!rst && (ib_ready || db_ready)) begin
      if (q1.size() == 0 || (ib_ready && db_ready)) begin
        check("dut1_unexpected_ready", 80'({ib_ready, db_ready}), 80'(0));
      end else begin
        e1 = q1.pop_front();
        check("dut1_response",
              80'({db_ready, db_ready ? db_rdata : ib_rdata, db_ready ? db_err : ib_err, 32'(cyc)}),
              80'({e1.m, e1.data, e1.err, 32'(e1.at)}));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (u2_ib_ready || u2_db_ready)) begin
      if (q2.size() == 0 || u2_db_ready) begin
        check("dut2_unexpected_ready", 80'({u2_ib_ready, u2_db_ready}), 80'(0));
      end else begin
        e2 = q2.pop_front();
        check("dut2_response", 80'({u2_ib_rdata, u2_ib_err, 32'(cyc)}),
              80'({e2.data, e2.err, 32'(e2.at)}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic m, input logic [31:0] data, input int at);
    exp_t e;
    e.m = m; e.data = data; e.err = 1'b0; e.at = at;
    q1.push_back(e);
  endtask

  // Drive one master's request now, hold until its ready, then drop it
  task automatic run_master(input logic m, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] mask);
    bit seen = 1'b0;
    if (m) begin
      db_req = 1'b1; db_we = we; db_addr = addr; db_wdata = data; db_mask = mask;
    end else begin
      ib_req = 1'b1; ib_we = we; ib_addr = addr; ib_wdata = data; ib_mask = mask;
    end
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = m ? db_ready : ib_ready;
    end
    check(m ? "dbus_ready_seen" : "ibus_ready_seen", 80'(seen), 80'(1));
    tick();
    if (m) db_req = 1'b0;
    else   ib_req = 1'b0;
  endtask

  int  t0;
  bit  seen2;

  initial begin
    ib_req = 0; ib_we = 0; ib_addr = 0; ib_wdata = 0; ib_mask = 0;
    db_req = 0; db_we = 0; db_addr = 0; db_wdata = 0; db_mask = 0;
    i2_req = 0; i2_addr = 0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 80'({mem_req, mem_we, mem_mask, busy, ib_ready, db_ready, ib_err, db_err,
                             mem_addr, mem_wdata}), 80'(0));
    check("reset_data", 80'({ib_rdata, db_rdata}), 80'(0));
    tick();
    rst = 1'b0;

    // Single ibus read, combinational slave
    slave_delay = 0;
    slave_key   = 32'hDEAD_BEEF ^ 32'h8000_0004;
    tick(); t0 = cyc;
    push1(1'b0, 32'hDEAD_BEEF, t0 + 2);
    fork
      run_master(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'hF);
      begin
        @(negedge clk); check("t1_mem_req_c0", 80'(mem_req), 80'(0));
        @(negedge clk); check("t1_mem_req_c1", 80'({mem_req, busy}), 80'(2'b11));
        @(negedge clk); check("t1_mem_req_c2", 80'({mem_req, busy, db_ready}), 80'(3'b010));
      end
    join

    // dbus write, slave answers at cycle 6
    slave_delay = 5;
    slave_key   = 32'hCAFE_0000;
    tick(); t0 = cyc;
    push1(1'b1, 32'h4AFE_0100, t0 + 7);
    fork
      run_master(1'b1, 1'b1, 32'h8000_0100, 32'h1234_5678, 4'h3);
      begin
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          check("t2_mem_hold", 80'({mem_req, mem_we, mem_mask, mem_addr, mem_wdata}),
                80'({1'b1, 1'b1, 4'h3, 32'h8000_0100, 32'h1234_5678}));
        end
      end
    join

    // Tie after a dbus grant
    slave_delay = 0;
    slave_key   = 32'h1111_0000;
    tick(); t0 = cyc;
`ifdef ARB_RR_EN
    push1(1'b0, 32'h1111_0100, t0 + 2);
    push1(1'b1, 32'h1111_0200, t0 + 5);
`else
    push1(1'b1, 32'h1111_0200, t0 + 2);
    push1(1'b0, 32'h1111_0100, t0 + 5);
`endif
    fork
      run_master(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
      run_master(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
    join

    // Lone ibus, then a tie: dbus wins in both modes
    tick(); t0 = cyc;
    push1(1'b0, 32'h1111_0300, t0 + 2);
    run_master(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
    tick(); t0 = cyc;
    push1(1'b1, 32'h1111_0400, t0 + 2);
    push1(1'b0, 32'h1111_0500, t0 + 5);
    fork
      run_master(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
      run_master(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    join

    // Reset during ACCESS abandons the transfer
    slave_delay = 10;
    tick();
    ib_req = 1'b1; ib_we = 1'b0; ib_addr = 32'h0000_0600; ib_mask = 4'hF;
    repeat (4) @(negedge clk);
    check("t5_in_access", 80'({mem_req, busy}), 80'(2'b11));
    rst = 1'b1;
    #1;
    check("t5_rst_ctrl", 80'({mem_req, mem_we, mem_mask, busy, ib_ready, db_ready, ib_err, db_err,
                              mem_addr, mem_wdata}), 80'(0));
    check("t5_rst_data", 80'({ib_rdata, db_rdata}), 80'(0));
    ib_req = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // First tie after reset
    slave_delay = 0;
    tick(); t0 = cyc;
`ifdef ARB_RR_EN
    push1(1'b0, 32'h1111_0700, t0 + 2);
    push1(1'b1, 32'h1111_0800, t0 + 5);
`else
    push1(1'b1, 32'h1111_0800, t0 + 2);
    push1(1'b0, 32'h1111_0700, t0 + 5);
`endif
    fork
      run_master(1'b0, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
      run_master(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF);
    join

    // Watchdog on dut2 (TIMEOUT = 4)
    tick(); t0 = cyc;
    begin
      exp_t e;
      e.m = 1'b0; e.data = 32'h0; e.err = 1'b1; e.at = t0 + 5;
      q2.push_back(e);
    end
    i2_req = 1'b1; i2_addr = 32'h0000_0900;
    seen2 = 1'b0;
    for (int i = 0; i < 32 && !seen2; i++) begin
      @(negedge clk);
      seen2 = u2_ib_ready;
    end
    check("t4_ready_seen", 80'(seen2), 80'(1));
    tick();
    i2_req = 1'b0;
    @(negedge clk);
    check("t4_back_idle", 80'({u2_busy, u2_mem_req, u2_ib_err}), 80'(3'b001));

    repeat (3) @(negedge clk);
    check("sb1_drained", 80'(q1.size()), 80'(0));
    check("sb2_drained", 80'(q2.size()), 80'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
